// File: rtl/ram_req_master.sv
// Bus-side request master: turns AW/W and AR handshakes into single RAM
// requests toward an arbiter, with independent write/read FSMs and per-request timeouts.
module ram_req_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TMO    = 255
) (
  input  logic                  aclk_s,
  input  logic                  rst_n,
  // write address / data / response
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  // read address / response
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_W-1:0]     araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  // arbiter side
  output logic                  ram_wr_req,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_wstrb,
  output logic                  ram_wdata_ready,
  input  logic                  ram_wr_ack,
  output logic                  ram_rd_req,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic                  ram_rd_ack,
  input  logic [DATA_W-1:0]     ram_rdata,
  // FSM state visibility
  output logic [1:0]            w_state_dbg,
  output logic [1:0]            r_state_dbg
);

  // Handshake rule for every channel: a beat transfers on a rising edge
  // where valid and ready are both 1; the sender holds its payload stable
  // while valid=1 and ready=0, and the receiver may not retract ready on
  // its own once offered in a cycle.

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] TMO_L       = 8'(TMO);

  logic [1:0]          w_state, r_state;
  logic                aw_held, w_held;
  logic [7:0]          w_cnt, r_cnt;
  logic [7:0]          w_cnt_inc, r_cnt_inc;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_fire, w_fire;

  always_comb begin
    w_cnt_inc = w_cnt + 8'd1;
    r_cnt_inc = r_cnt + 8'd1;
    aw_fire   = awvalid && awready;
    w_fire    = wvalid && wready;
  end

  // Write FSM: collect AW and W in any order, then hold one request until ack or timeout.
  always_ff @(posedge aclk_s) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      w_cnt     <= 8'd0;
      bresp_q   <= RESP_OKAY;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held   <= 1'b1;
            wr_addr_q <= awaddr;
          end
          if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          if ((aw_held || aw_fire) && (w_held || w_fire)) begin
            w_state <= W_REQ;
            w_cnt   <= 8'd0;
          end
        end
        W_REQ: begin
          if (ram_wr_ack) begin
            w_state <= W_RESP;
            bresp_q <= RESP_OKAY;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else if (w_cnt_inc == TMO_L) begin
            w_state <= W_RESP;
            bresp_q <= RESP_SLVERR;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            w_cnt <= w_cnt_inc;
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one outstanding read; data returns the cycle after the grant.
  always_ff @(posedge aclk_s) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_cnt     <= 8'd0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rd_addr_q <= araddr;
            r_state   <= R_REQ;
            r_cnt     <= 8'd0;
          end
        end
        R_REQ: begin
          if (ram_rd_ack) begin
            r_state <= R_WAIT;
          end else if (r_cnt_inc == TMO_L) begin
            r_state <= R_RESP;
            rresp_q <= RESP_SLVERR;
            rdata_q <= '0;
          end else begin
            r_cnt <= r_cnt_inc;
          end
        end
        R_WAIT: begin
          rdata_q <= ram_rdata;
          rresp_q <= RESP_OKAY;
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only, so no input-to-output paths exist.
  always_comb begin
    awready         = (w_state == W_IDLE) && !aw_held;
    wready          = (w_state == W_IDLE) && !w_held;
    bvalid          = (w_state == W_RESP);
    bresp           = bresp_q;
    ram_wr_req      = (w_state != W_RESP) && aw_held;
    ram_wdata_ready = (w_state != W_RESP) && w_held;
    ram_wr_addr     = wr_addr_q;
    ram_wdata       = wdata_q;
    ram_wstrb       = wstrb_q;
    arready         = (r_state == R_IDLE);
    ram_rd_req      = (r_state == R_REQ);
    ram_rd_addr     = rd_addr_q;
    rvalid          = (r_state == R_RESP);
    rresp           = rresp_q;
    rdata           = rdata_q;
    w_state_dbg     = w_state;
    r_state_dbg     = r_state;
  end

endmodule

// File: tb/tb_ram_req_master.sv
// Directed bench for ram_req_master: write/read paths, concurrency,
// timeouts (TMO=4) and mid-transaction reset.
module tb_ram_req_master;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic                  aclk_s = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic                  arvalid = 1'b0, rready = 1'b0;
  logic [ADDR_W-1:0]     awaddr = '0, araddr = '0;
  logic [DATA_W-1:0]     wdata = '0, ram_rdata = '0;
  logic [DATA_W/8-1:0]   wstrb = '0;
  logic                  ram_wr_ack = 1'b0, ram_rd_ack = 1'b0;
  logic                  awready, wready, bvalid, arready, rvalid;
  logic [1:0]            bresp, rresp;
  logic [DATA_W-1:0]     rdata, ram_wdata;
  logic                  ram_wr_req, ram_wdata_ready, ram_rd_req;
  logic [ADDR_W-1:0]     ram_wr_addr, ram_rd_addr;
  logic [DATA_W/8-1:0]   ram_wstrb;
  logic [1:0]            w_state_dbg, r_state_dbg;

  int n_vec = 0;
  int n_err = 0;

  ram_req_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO(4)) dut (
    .aclk_s(aclk_s), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ram_wr_req(ram_wr_req), .ram_wr_addr(ram_wr_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_wdata_ready(ram_wdata_ready), .ram_wr_ack(ram_wr_ack),
    .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr), .ram_rd_ack(ram_rd_ack),
    .ram_rdata(ram_rdata),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // clock / reset
  always #5 aclk_s = ~aclk_s;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk_s);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd1);
    chk({tag, "_wready"}, 32'(wready), 32'd1);
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_wr_req"}, 32'(ram_wr_req), 32'd0);
    chk({tag, "_wdata_ready"}, 32'(ram_wdata_ready), 32'd0);
    chk({tag, "_rd_req"}, 32'(ram_rd_req), 32'd0);
    chk({tag, "_bresp"}, 32'(bresp), 32'd0);
    chk({tag, "_rresp"}, 32'(rresp), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // single write: AW in cycle 0, W in cycle 2, ack in cycle 4
    awvalid = 1'b1; awaddr = 16'h0010;
    tick();                                      // cycle 1
    awvalid = 1'b0;
    chk("wr_req_c1", 32'(ram_wr_req), 32'd1);
    chk("wr_addr_c1", 32'(ram_wr_addr), 32'h0010);
    chk("awready_c1", 32'(awready), 32'd0);
    chk("wdrdy_c1", 32'(ram_wdata_ready), 32'd0);
    chk("wready_c1", 32'(wready), 32'd1);
    tick();                                      // cycle 2
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();                                      // cycle 3
    wvalid = 1'b0; wdata = 32'h0;
    chk("wdrdy_c3", 32'(ram_wdata_ready), 32'd1);
    chk("wdata_c3", ram_wdata, 32'hDEADBEEF);
    chk("wstrb_c3", 32'(ram_wstrb), 32'hF);
    chk("wready_c3", 32'(wready), 32'd0);
    chk("wstate_c3", 32'(w_state_dbg), 32'd1);
    tick();                                      // cycle 4
    ram_wr_ack = 1'b1;
    chk("bvalid_c4", 32'(bvalid), 32'd0);
    tick();                                      // cycle 5
    ram_wr_ack = 1'b0;
    chk("bvalid_c5", 32'(bvalid), 32'd1);
    chk("bresp_c5", 32'(bresp), 32'd0);
    chk("wr_req_c5", 32'(ram_wr_req), 32'd0);
    chk("wdrdy_c5", 32'(ram_wdata_ready), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_done", 32'(bvalid), 32'd0);
    chk("awready_done", 32'(awready), 32'd1);

    // single read with rready back-pressure
    arvalid = 1'b1; araddr = 16'h0020;
    tick();                                      // H+1
    arvalid = 1'b0;
    chk("rd_req_h1", 32'(ram_rd_req), 32'd1);
    chk("rd_addr_h1", 32'(ram_rd_addr), 32'h0020);
    chk("arready_h1", 32'(arready), 32'd0);
    ram_rd_ack = 1'b1;
    tick();                                      // H+2
    ram_rd_ack = 1'b0; ram_rdata = 32'h12345678;
    chk("rd_req_h2", 32'(ram_rd_req), 32'd0);
    chk("rvalid_h2", 32'(rvalid), 32'd0);
    tick();                                      // H+3
    ram_rdata = 32'hFFFF_FFFF;
    chk("rvalid_h3", 32'(rvalid), 32'd1);
    chk("rdata_h3", rdata, 32'h12345678);
    chk("rresp_h3", 32'(rresp), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, 32'h12345678);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_done", 32'(rvalid), 32'd0);
    chk("arready_done", 32'(arready), 32'd1);

    // concurrent write + read, read acked first, write next cycle
    awvalid = 1'b1; awaddr = 16'h0044; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    arvalid = 1'b1; araddr = 16'h0088;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("cc_wr_req", 32'(ram_wr_req), 32'd1);
    chk("cc_wdrdy", 32'(ram_wdata_ready), 32'd1);
    chk("cc_rd_req", 32'(ram_rd_req), 32'd1);
    chk("cc_rd_addr", 32'(ram_rd_addr), 32'h0088);
    ram_rd_ack = 1'b1;
    tick();
    ram_rd_ack = 1'b0; ram_rdata = 32'hA5A50F0F;
    chk("cc_wr_req_hold", 32'(ram_wr_req), 32'd1);
    chk("cc_wr_addr_hold", 32'(ram_wr_addr), 32'h0044);
    chk("cc_wdata_hold", ram_wdata, 32'hCAFEF00D);
    chk("cc_wstrb_hold", 32'(ram_wstrb), 32'h3);
    chk("cc_rd_req_drop", 32'(ram_rd_req), 32'd0);
    ram_wr_ack = 1'b1;
    tick();
    ram_wr_ack = 1'b0; ram_rdata = 32'h0;
    chk("cc_rvalid", 32'(rvalid), 32'd1);
    chk("cc_rdata", rdata, 32'hA5A50F0F);
    chk("cc_rresp", 32'(rresp), 32'd0);
    chk("cc_bvalid", 32'(bvalid), 32'd1);
    chk("cc_bresp", 32'(bresp), 32'd0);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("cc_idle_w", 32'(w_state_dbg), 32'd0);
    chk("cc_idle_r", 32'(r_state_dbg), 32'd0);

    // read timeout: never acked, TMO=4
    arvalid = 1'b1; araddr = 16'h0030;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_rd_req_on", 32'(ram_rd_req), 32'd1);
      tick();
    end
    chk("to_rd_req_off", 32'(ram_rd_req), 32'd0);
    chk("to_rvalid", 32'(rvalid), 32'd1);
    chk("to_rresp", 32'(rresp), 32'd2);
    chk("to_rdata", rdata, 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // ack in the timeout cycle wins
    arvalid = 1'b1; araddr = 16'h0034;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("tw_rd_req_c4", 32'(ram_rd_req), 32'd1);
    ram_rd_ack = 1'b1;
    tick();
    ram_rd_ack = 1'b0; ram_rdata = 32'h0BADCAFE;
    tick();
    ram_rdata = 32'h0;
    chk("tw_rvalid", 32'(rvalid), 32'd1);
    chk("tw_rresp", 32'(rresp), 32'd0);
    chk("tw_rdata", rdata, 32'h0BADCAFE);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // write timeout
    awvalid = 1'b1; awaddr = 16'h0050; wvalid = 1'b1; wdata = 32'h11112222; wstrb = 4'h1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wto_wr_req_on", 32'(ram_wr_req), 32'd1);
      tick();
    end
    chk("wto_wr_req_off", 32'(ram_wr_req), 32'd0);
    chk("wto_bvalid", 32'(bvalid), 32'd1);
    chk("wto_bresp", 32'(bresp), 32'd2);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // reset while in W_REQ, then a stray ack
    awvalid = 1'b1; awaddr = 16'h0060; wvalid = 1'b1; wdata = 32'h33334444; wstrb = 4'hC;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("mr_in_wreq", 32'(w_state_dbg), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("mr");
    chk("mr_wr_addr", 32'(ram_wr_addr), 32'd0);
    ram_wr_ack = 1'b1;
    tick();
    ram_wr_ack = 1'b0;
    chk("mr_stray_bvalid", 32'(bvalid), 32'd0);
    chk("mr_stray_wr_req", 32'(ram_wr_req), 32'd0);
    chk("mr_stray_awready", 32'(awready), 32'd1);
    tick();
    chk("mr_stray_bvalid2", 32'(bvalid), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
